// File: rtl/cache_axi_bridge.sv
// ============================================================================
// Module  : cache_axi_bridge
// Purpose : d-cache single-beat request port to AXI master, one outstanding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cache_axi_bridge #(
  parameter int PHYS_MAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  // cache side
  input  logic        s_req,
  input  logic        s_wr,
  input  logic [1:0]  s_size,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        s_addr_ok,
  output logic        s_data_ok,
  // AXI read address / data
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_AR = 3'd1,
    RD_R  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] addr_lat;
  logic [31:0] wdata_lat;
  logic [1:0]  size_lat;
  logic [3:0]  wstrb_lat;
  logic        aw_done;
  logic        w_done;

  logic [31:0] mapped_addr;
  logic [3:0]  req_wstrb;

  // kseg0/kseg1 both alias the low 512 MB of physical space
  generate
    if (PHYS_MAP != 0) begin : g_phys_map
      assign mapped_addr = (s_addr[31:30] == 2'b10) ? {3'b000, s_addr[28:0]} : s_addr;
    end else begin : g_no_map
      assign mapped_addr = s_addr;
    end
  endgenerate

  always_comb begin
    req_wstrb = 4'b1111;
    case (s_size)
      2'd0:    req_wstrb = 4'b0001 << s_addr[1:0];
      2'd1:    req_wstrb = s_addr[1] ? 4'b1100 : 4'b0011;
      default: req_wstrb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lat  <= 32'd0;
      wdata_lat <= 32'd0;
      size_lat  <= 2'd0;
      wstrb_lat <= 4'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else if (s_addr_ok) begin
      addr_lat  <= mapped_addr;
      wdata_lat <= s_wdata;
      size_lat  <= s_size;
      wstrb_lat <= req_wstrb;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = 32'd0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        s_addr_ok = s_req;
        if (s_req) state_nxt = s_wr ? WR_AW : RD_AR;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          s_data_ok = 1'b1;
          s_rdata   = rdata;
          state_nxt = IDLE;
        end
      end
      WR_AW: begin
        // AW and W complete independently; a handshake this cycle counts as done
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          s_data_ok = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign araddr = addr_lat;
  assign arsize = {1'b0, size_lat};
  assign awaddr = addr_lat;
  assign awsize = {1'b0, size_lat};
  assign wdata  = wdata_lat;
  assign wstrb  = wstrb_lat;

endmodule

`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
// ============================================================================
// Module  : tb_cache_axi_bridge
// Purpose : directed + randomized bench for cache_axi_bridge (mapped and raw).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cache_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;

  logic [31:0] m_s_rdata, m_araddr, m_awaddr, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [3:0]  m_wstrb;
  logic        m_s_addr_ok, m_s_data_ok, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;

  logic [31:0] p_s_rdata, p_araddr, p_awaddr, p_wdata;
  logic [2:0]  p_arsize, p_awsize;
  logic [3:0]  p_wstrb;
  logic        p_s_addr_ok, p_s_data_ok, p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;

  int tests = 0;
  int fails = 0;

  cache_axi_bridge #(.PHYS_MAP(1)) dut_map (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(m_s_rdata), .s_addr_ok(m_s_addr_ok), .s_data_ok(m_s_data_ok),
    .araddr(m_araddr), .arsize(m_arsize), .arvalid(m_arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(m_rready),
    .awaddr(m_awaddr), .awsize(m_awsize), .awvalid(m_awvalid), .awready(awready),
    .wdata(m_wdata), .wstrb(m_wstrb), .wvalid(m_wvalid), .wready(wready),
    .bvalid(bvalid), .bready(m_bready)
  );

  cache_axi_bridge #(.PHYS_MAP(0)) dut_raw (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(p_s_rdata), .s_addr_ok(p_s_addr_ok), .s_data_ok(p_s_data_ok),
    .araddr(p_araddr), .arsize(p_arsize), .arvalid(p_arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(p_rready),
    .awaddr(p_awaddr), .awsize(p_awsize), .awvalid(p_awvalid), .awready(awready),
    .wdata(p_wdata), .wstrb(p_wstrb), .wvalid(p_wvalid), .wready(wready),
    .bvalid(bvalid), .bready(p_bready)
  );

  // Physical address as the mapped instance should present it
  function automatic logic [31:0] phys(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
    if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
    return a;
  endfunction

  // Byte lanes covered by an access of 2**size bytes (reserved size = full word)
  function automatic logic [3:0] lanes(input int size, input logic [31:0] a);
    int n, off, base;
    n    = (size >= 2) ? 4 : (1 << size);
    off  = int'(a % 4);
    base = off - (off % n);
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [6:0] ctl_m();
    return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, m_s_addr_ok, m_s_data_ok};
  endfunction

  function automatic logic [6:0] ctl_p();
    return {p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready, p_s_addr_ok, p_s_data_ok};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ctl bit order: arvalid rready awvalid wvalid bready s_addr_ok s_data_ok
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk({tag, ":ctl_map"}, 32'(ctl_m()), 32'(exp));
    chk({tag, ":ctl_raw"}, 32'(ctl_p()), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit keep, input string tag);
    s_req = 1'b1; s_wr = wr; s_size = sz; s_addr = a; s_wdata = wd;
    sample();
    chk_ctl({tag, "/accept"}, 7'b0000010);
    tick();
    if (!keep) begin
      // scramble the cache-side inputs so the bridge must rely on its latches
      s_req = 1'b0; s_wr = 1'($urandom); s_size = 2'($urandom);
      s_addr = $urandom; s_wdata = $urandom;
    end
  endtask

  task automatic read_phase(input logic [31:0] a, input logic [1:0] sz, input int ar_dly,
                            input int r_dly, input logic [31:0] data, input string tag);
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      sample();
      chk_ctl({tag, "/ar"}, 7'b1000000);
      chk({tag, "/araddr_map"}, m_araddr, phys(a));
      chk({tag, "/araddr_raw"}, p_araddr, a);
      chk({tag, "/arsize"}, 32'(m_arsize), 32'({1'b0, sz}));
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      rvalid = (i == r_dly);
      rdata  = rvalid ? data : $urandom;
      sample();
      chk_ctl({tag, "/r"}, {1'b0, 1'b1, 4'b0000, rvalid});
      if (rvalid) begin
        chk({tag, "/rdata_map"}, m_s_rdata, data);
        chk({tag, "/rdata_raw"}, p_s_rdata, data);
      end
      tick();
    end
    rvalid = 1'b0;
  endtask

  task automatic write_phase(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                             input int aw_dly, input int w_dly, input int b_dly, input string tag);
    bit aw_pend = 1'b1;
    bit w_pend  = 1'b1;
    int c = 0;
    while (aw_pend || w_pend) begin
      awready = (c >= aw_dly);
      wready  = (c >= w_dly);
      sample();
      chk_ctl({tag, "/aw_w"}, {2'b00, aw_pend, w_pend, 3'b000});
      if (aw_pend) begin
        chk({tag, "/awaddr_map"}, m_awaddr, phys(a));
        chk({tag, "/awaddr_raw"}, p_awaddr, a);
        chk({tag, "/awsize"}, 32'(m_awsize), 32'({1'b0, sz}));
      end
      if (w_pend) begin
        chk({tag, "/wdata"}, m_wdata, wd);
        chk({tag, "/wstrb"}, 32'(m_wstrb), 32'(lanes(int'(sz), a)));
        chk({tag, "/wstrb_raw"}, 32'(p_wstrb), 32'(lanes(int'(sz), a)));
      end
      tick();
      if (awready) aw_pend = 1'b0;
      if (wready)  w_pend  = 1'b0;
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int i = 0; i <= b_dly; i++) begin
      bvalid = (i == b_dly);
      sample();
      chk_ctl({tag, "/b"}, {4'b0000, 1'b1, 1'b0, bvalid});
      tick();
    end
    bvalid = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    sample();
    chk_ctl({tag, "/idle"}, 7'b0000000);
    tick();
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        wr;

    rst = 1'b1; s_req = 1'b0; s_wr = 1'b0; s_size = 2'd0; s_addr = 32'd0; s_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    tick(); tick();
    sample();
    chk_ctl("reset", 7'b0000000);
    chk("reset/s_rdata_map", m_s_rdata, 32'd0);
    chk("reset/s_rdata_raw", p_s_rdata, 32'd0);
    tick();
    rst = 1'b0;
    idle_check("post_reset");

    // kseg0 read with AR back-pressure
    issue(1'b0, 2'd2, 32'h8000_0010, 32'd0, 1'b0, "t1");
    read_phase(32'h8000_0010, 2'd2, 2, 0, 32'hDEAD_BEEF, "t1");
    idle_check("t1");

    // kseg1 byte write in the top lane
    issue(1'b1, 2'd0, 32'hA000_0003, 32'hAB00_0000, 1'b0, "t2");
    write_phase(32'hA000_0003, 2'd0, 32'hAB00_0000, 0, 0, 1, "t2");
    idle_check("t2");

    // W accepted well before AW
    issue(1'b1, 2'd2, 32'h8000_1234, 32'h1234_5678, 1'b0, "t3");
    write_phase(32'h8000_1234, 2'd2, 32'h1234_5678, 3, 0, 0, "t3");
    idle_check("t3");

    // second request held through the first read
    issue(1'b0, 2'd2, 32'h8000_0100, 32'd0, 1'b1, "t4a");
    s_addr = 32'h8000_0200;
    read_phase(32'h8000_0100, 2'd2, 0, 2, 32'hCAFE_0001, "t4a");
    issue(1'b0, 2'd2, 32'h8000_0200, 32'd0, 1'b0, "t4b");
    read_phase(32'h8000_0200, 2'd2, 1, 0, 32'hCAFE_0002, "t4b");
    idle_check("t4");

    // halfword write in the upper half (raw instance keeps the address)
    issue(1'b1, 2'd1, 32'h0000_0002, 32'hBEEF_0000, 1'b0, "t5");
    write_phase(32'h0000_0002, 2'd1, 32'hBEEF_0000, 1, 1, 0, "t5");
    idle_check("t5");

    // reset while waiting on R
    issue(1'b0, 2'd2, 32'h8000_0040, 32'd0, 1'b0, "t6r");
    arready = 1'b1; tick(); arready = 1'b0;
    rst = 1'b1;
    sample();
    chk_ctl("t6r/pre", 7'b0100000);
    tick();
    rst = 1'b0; rvalid = 1'b1; bvalid = 1'b1; rdata = 32'h5555_AAAA;
    sample();
    chk_ctl("t6r/after", 7'b0000000);
    tick();
    sample();
    chk_ctl("t6r/after2", 7'b0000000);
    tick();
    rvalid = 1'b0; bvalid = 1'b0;

    // reset while AW/W outstanding
    issue(1'b1, 2'd2, 32'h8000_0080, 32'h0F0F_0F0F, 1'b0, "t6w");
    rst = 1'b1;
    sample();
    chk_ctl("t6w/pre", 7'b0011000);
    tick();
    rst = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; rvalid = 1'b1;
    sample();
    chk_ctl("t6w/after", 7'b0000000);
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    issue(1'b0, 2'd0, 32'hA000_0005, 32'd0, 1'b0, "t6_recover");
    read_phase(32'hA000_0005, 2'd0, 0, 0, 32'h0000_7700, "t6_recover");
    idle_check("t6");

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[31:29] = 3'($urandom_range(4, 5));
      d  = $urandom;
      issue(wr, sz, a, d, 1'b0, "rnd");
      if (wr)
        write_phase(a, sz, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), "rnd");
      else
        read_phase(a, sz, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, "rnd");
      if ($urandom_range(0, 1) == 1) idle_check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
